// File: rtl/transmit_arbiter_if.sv
// transmit_arbiter_if: requester streams, the stream toward the transmit
// serializer, and arbitration status for transmit_arbiter.
// master: the arbiter's view. slave: the requesters/serializer side.
interface transmit_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           expired;

  modport master (
    input  req_data, req_valid, req_last, out_ready,
    output req_ready, out_data, out_valid, grant, expired
  );

  modport slave (
    output req_data, req_valid, req_last, out_ready,
    input  req_ready, out_data, out_valid, grant, expired
  );
endinterface

// File: rtl/transmit_arbiter.sv
// transmit_arbiter: round-robin, message-atomic arbiter sharing one transmit
// serializer among N byte streams. A granted requester keeps the serializer
// until its last byte transfers. No data is buffered; the owner's stream is
// muxed straight through.
// Optional feature: define TRANSMIT_ARBITER_TIMEOUT_EN to revoke a grant after
// TIMEOUT consecutive owner-idle cycles (pulses expired).
module transmit_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  transmit_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] grant_reg, grant_next;
  logic [3:0]   ptr_reg, ptr_next;
  logic [3:0]   owner_reg, owner_next;
  logic [3:0]   owner_inc;

  logic [3:0]   cand_idx [N];
  logic [N-1:0] valid_rot;
  logic [N-1:0] pick_onehot;
  logic [3:0]   pick_idx;
  logic         pick_found;

  logic [W-1:0] data_masked [N];
  logic [W-1:0] out_data_mux;
  logic         owner_valid;
  logic         owner_last;
  logic         xfer;
  logic         timeout_hit;

  // Candidate k is requester (ptr + k) mod N, so k = 0 has top priority.
  // The owner mux is AND-OR over the one-hot grant, which is zero in IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [4:0] sum;
      assign sum              = {1'b0, ptr_reg} + 5'(gi);
      assign cand_idx[gi]     = (sum >= 5'(N)) ? 4'(sum - 5'(N)) : sum[3:0];
      assign valid_rot[gi]    = bus.req_valid[cand_idx[gi][IW-1:0]];
      assign pick_onehot[gi]  = (pick_idx == 4'(gi));
      assign data_masked[gi]  = bus.req_data[gi*W +: W] & {W{grant_reg[gi]}};
    end
  endgenerate

  // Pick the first valid requester at or above ptr, wrapping modulo N.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        pick_idx   = cand_idx[k];
        pick_found = 1'b1;
      end
    end
  end

  // Merge the masked owner data onto the single output lane.
  always_comb begin
    out_data_mux = '0;
    for (int k = 0; k < N; k++) begin
      out_data_mux = out_data_mux | data_masked[k];
    end
  end

  assign owner_valid = |(bus.req_valid & grant_reg);
  assign owner_last  = |(bus.req_last & grant_reg);
  assign xfer        = owner_valid & bus.out_ready;
  assign owner_inc   = (owner_reg == 4'(N - 1)) ? 4'd0 : owner_reg + 4'd1;

  assign bus.out_valid = owner_valid;
  assign bus.out_data  = out_data_mux;
  assign bus.req_ready = grant_reg & {N{bus.out_ready}};
  assign bus.grant     = grant_reg;

`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
  logic [15:0] stall_reg;
  logic        expired_reg;

  // The counter's increment that would make it equal TIMEOUT instead revokes.
  assign timeout_hit = (state_reg == GRANT) && !owner_valid &&
                       (stall_reg == 16'(TIMEOUT - 1));
  assign bus.expired = expired_reg;

  // Count consecutive owner-idle GRANT cycles; stalls on ready never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (state_reg != GRANT || state_next != state_reg || owner_valid) begin
      stall_reg <= '0;
    end else begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  // One-cycle pulse in the first IDLE cycle after a revoked grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      expired_reg <= 1'b0;
    end else begin
      expired_reg <= timeout_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign bus.expired    = 1'b0;
`endif

  // Next-state: grant from IDLE, release on last transfer or timeout.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          grant_next = pick_onehot;
          owner_next = pick_idx;
        end
      end
      GRANT: begin
        if ((xfer && owner_last) || timeout_hit) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and rotation pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end
endmodule

// File: tb/tb_transmit_arbiter.sv
// tb_transmit_arbiter: directed scoreboard bench for transmit_arbiter.
// Requester queues feed the DUT; a monitor checks every transfer against the
// expected-byte queue. Define TRANSMIT_ARBITER_TIMEOUT_EN to test the timeout.
module tb_transmit_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  typedef struct {
    logic [7:0] data;
    int         src;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [8:0] rq [N][$];
  logic [N-1:0] pause = '0;
  exp_t exp_q[$];
  int   xfer_cyc[$];

  transmit_arbiter_if #(.N(N), .W(W)) bus ();

  transmit_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_byte(input logic [7:0] d, input int src);
    exp_t e;
    e.data = d;
    e.src  = src;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    pause = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Requester driver: pop on handshake, present the queue head after each edge.
  initial begin
    logic [N-1:0] fire;
    logic [8:0]   head;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !pause[i]) begin
          head = rq[i][0];
          bus.req_valid[i]       = 1'b1;
          bus.req_data[i*W +: W] = head[7:0];
          bus.req_last[i]        = head[8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[i*W +: W] = '0;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted byte must match the next expected byte and owner.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got data %0h grant %0h expected none", bus.out_data, bus.grant);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data", 32'(bus.out_data), 32'(e.data));
          check("xfer_grant", 32'(bus.grant), 32'(1) << e.src);
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    do_reset();

    // Reset values
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_expired", 32'(bus.expired), 32'd0);

    // Single requester: latency and grant window
    send(0, 8'hA5, 1'b1);
    expect_byte(8'hA5, 0);
    @(negedge clk);
    check("t1_grant_c1", 32'(bus.grant), 32'd0);
    check("t1_valid_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("t1_grant_c2", 32'(bus.grant), 32'b0001);
    check("t1_valid_c2", 32'(bus.out_valid), 32'd1);
    check("t1_data_c2", 32'(bus.out_data), 32'hA5);
    @(negedge clk);
    check("t1_grant_c3", 32'(bus.grant), 32'd0);
    // ptr is now 1: requester 1 beats requester 0
    send(0, 8'h20, 1'b1);
    send(1, 8'h21, 1'b1);
    expect_byte(8'h21, 1);
    expect_byte(8'h20, 0);
    drain();

    // Contention with one idle bubble between messages
    do_reset();
    xfer_cyc.delete();
    for (int i = 0; i < N; i++) begin
      send(i, 8'(8'h10 + i), 1'b1);
      expect_byte(8'(8'h10 + i), i);
    end
    drain();
    check("t2_xfer_count", 32'(xfer_cyc.size()), 32'd4);
    if (xfer_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t2_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd2);
    end

    // Message atomicity with backpressure, requester 1 pending
    do_reset();
    send(2, 8'h01, 1'b0);
    send(2, 8'h02, 1'b0);
    send(2, 8'h03, 1'b1);
    expect_byte(8'h01, 2);
    expect_byte(8'h02, 2);
    expect_byte(8'h03, 2);
    expect_byte(8'h77, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) send(1, 8'h77, 1'b1);
      check("t3_ready1_low", 32'(bus.req_ready[1]), 32'd0);
      if (k == 3) begin
        check("t3_stall_valid", 32'(bus.out_valid), 32'd1);
        check("t3_stall_data", 32'(bus.out_data), 32'h02);
      end
      if (k == 2) begin
        @(posedge clk);
        #2 bus.out_ready = 1'b0;
      end
      if (k == 4) begin
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    end
    drain();

    // Rotation wrap: serve 2 (ptr=3), then 3 before 0, leaving ptr=1
    do_reset();
    send(2, 8'h30, 1'b1);
    expect_byte(8'h30, 2);
    drain();
    send(0, 8'h31, 1'b1);
    send(3, 8'h32, 1'b1);
    expect_byte(8'h32, 3);
    expect_byte(8'h31, 0);
    drain();
    send(0, 8'h33, 1'b1);
    send(1, 8'h34, 1'b1);
    expect_byte(8'h34, 1);
    expect_byte(8'h33, 0);
    drain();

    // Reset mid-message
    do_reset();
    send(2, 8'h41, 1'b0);
    send(2, 8'h42, 1'b0);
    send(2, 8'h43, 1'b1);
    expect_byte(8'h41, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rq[2].delete();
    send(1, 8'h55, 1'b1);
    expect_byte(8'h55, 1);
    @(negedge clk);
    rst = 1'b0;
    check("t5_grant_rst", 32'(bus.grant), 32'd0);
    check("t5_valid_rst", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("t5_grant_after", 32'(bus.grant), 32'b0010);
    check("t5_data_after", 32'(bus.out_data), 32'h55);
    drain();

    // Owner drops valid mid-message
    do_reset();
    send(0, 8'hC1, 1'b0);
    send(0, 8'hC2, 1'b1);
    send(1, 8'h66, 1'b1);
    expect_byte(8'hC1, 0);
`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
    expect_byte(8'h66, 1);
    expect_byte(8'hC2, 0);
`else
    expect_byte(8'hC2, 0);
    expect_byte(8'h66, 1);
`endif
    @(negedge clk);
    @(negedge clk);
    pause[0] = 1'b1;
`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      check("t6_expired_low", 32'(bus.expired), 32'd0);
      check("t6_grant_held", 32'(bus.grant), 32'b0001);
    end
    @(negedge clk);
    check("t6_expired_pulse", 32'(bus.expired), 32'd1);
    check("t6_grant_cleared", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("t6_expired_end", 32'(bus.expired), 32'd0);
    check("t6_next_grant", 32'(bus.grant), 32'b0010);
`else
    repeat (1000) @(negedge clk);
    check("t6_grant_held", 32'(bus.grant), 32'b0001);
    check("t6_valid_low", 32'(bus.out_valid), 32'd0);
    check("t6_expired_tied", 32'(bus.expired), 32'd0);
`endif
    pause[0] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
